// File: rtl/toll_gate_seq_ctrl.sv
// Toll-lane sequencer for several vehicles in the lane at once: time measure, E-pass decision and barrier control.
// Vehicle counters wrap, so a vehicle is pending whenever two counters differ.
`timescale 1ns/1ps

module toll_gate_seq_ctrl #(
  parameter int CNT_W   = 4,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sensor1,
  input  logic             sensor2,
  input  logic             sensor3,
  input  logic [1:0]       valid_epass,
  input  logic             enable,
  output logic             init,
  output logic             count,
  output logic             cal,
  output logic             dis,
  output logic             up,
  output logic             down,
  output logic             err,
  output logic             ovf,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {S_IDLE, S_TIMING, S_DECIDE, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] OCC_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] in_cnt, meas_cnt, out_cnt, dec_cnt, auth_cnt;
  logic [CNT_W-1:0] out_cnt_inc;
  logic [TMO_W-1:0] timer;
  logic             gate_open;
  logic             s1_d, s2_d, s3_d;
  logic             rise1, rise2, fall3;
  logic             lane_full;
  logic             authorise, verdict, timeout, down_qual;

  assign rise1       = sensor1 & ~s1_d;
  assign rise2       = sensor2 & ~s2_d;
  assign fall3       = ~sensor3 & s3_d;
  assign occupancy   = in_cnt - out_cnt;
  assign lane_full   = (occupancy == OCC_MAX);
  assign out_cnt_inc = out_cnt + 1'b1;
  // The barrier closes only once the most recently authorised vehicle has left.
  assign down_qual   = fall3 & gate_open & (out_cnt_inc == auth_cnt);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    authorise = 1'b0;
    verdict   = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      S_IDLE:   if (in_cnt != dec_cnt) state_nxt = S_TIMING;
      S_TIMING: if (meas_cnt != dec_cnt) state_nxt = S_DECIDE;
      S_DECIDE: begin
        // A verdict on the final timeout cycle takes priority over the timeout.
        if (valid_epass == 2'b10) begin
          authorise = 1'b1;
          verdict   = 1'b1;
          state_nxt = S_IDLE;
        end else if (valid_epass == 2'b01) begin
          verdict   = 1'b1;
          state_nxt = S_HOLD;
        end else if (timer == TMO_LAST) begin
          timeout   = 1'b1;
          verdict   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (enable) begin
          authorise = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state     <= S_IDLE;
      s1_d      <= 1'b0;
      s2_d      <= 1'b0;
      s3_d      <= 1'b0;
      in_cnt    <= '0;
      meas_cnt  <= '0;
      out_cnt   <= '0;
      dec_cnt   <= '0;
      auth_cnt  <= '0;
      timer     <= '0;
      gate_open <= 1'b0;
      ovf       <= 1'b0;
      init      <= 1'b1;
      count     <= 1'b0;
      cal       <= 1'b0;
      dis       <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      err       <= 1'b0;
    end else begin
      s1_d  <= sensor1;
      s2_d  <= sensor2;
      s3_d  <= sensor3;
      state <= state_nxt;
      init  <= (state_nxt == S_IDLE);
      count <= (state_nxt == S_TIMING);
      cal   <= (state_nxt == S_DECIDE);
      dis   <= (state_nxt == S_HOLD);
      err   <= timeout;
      up    <= 1'b0;
      down  <= 1'b0;

      if (rise1) begin
        if (lane_full) ovf <= 1'b1;
        else           in_cnt <= in_cnt + 1'b1;
      end
      if (rise2)   meas_cnt <= meas_cnt + 1'b1;
      if (fall3)   out_cnt  <= out_cnt_inc;
      if (verdict) dec_cnt  <= dec_cnt + 1'b1;

      if (state == S_TIMING)      timer <= '0;
      else if (state == S_DECIDE) timer <= timer + 1'b1;

      // Authorisation outranks a same-cycle exit: the gate stays open with no pulse.
      if (authorise) begin
        auth_cnt <= auth_cnt + 1'b1;
        if (!gate_open) begin
          up        <= 1'b1;
          gate_open <= 1'b1;
        end
      end else if (down_qual) begin
        down      <= 1'b1;
        gate_open <= 1'b0;
      end
    end
  end

endmodule
